pipelined_cla_alu: RTL

PIPELINED_CLA_ALU -- requirements
Module: pipelined_cla_alu

---
 rtl/pipelined_cla_alu.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/pipelined_cla_alu.sv
// Pipelined ALU built around a two-level carry-lookahead adder.
// Four-bit groups produce group propagate/generate and speculative sums for
// both possible group carry-ins; a second lookahead level resolves the
// inter-group carries and selects the final sum. With STAGES=2 the group
// terms are registered between the two levels; with STAGES=1 the whole
// datapath feeds a single output register. Each stage holds one entry and
// uses valid/ready handshaking.
module pipelined_cla_alu #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic [2:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             slt,
  output logic             zero
);

  localparam int NG = WIDTH / 4;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // Everything the second lookahead level needs to finish an operation.
  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] logic_res;
    logic [WIDTH-1:0] sum0;
    logic [WIDTH-1:0] sum1;
    logic [NG-1:0]    gp;
    logic [NG-1:0]    gg;
    logic             c0;
    logic             a_msb;
    logic             bx_msb;
  } stage1_t;

  stage1_t    s1_next;
  stage1_t    src;
  logic       src_valid;
  logic       out_load;

  logic [NG:0]      gc;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] next_result;
  logic             next_carry;
  logic             next_overflow;
  logic             next_slt;

  // Four-bit lookahead sum: all internal carries are flattened, no ripple.
  function automatic logic [3:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic cin);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;
    p    = x ^ y;
    g    = x & y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return p ^ c;
  endfunction

  // First level: operand conditioning, logic ops, group P/G and speculative group sums.
  always_comb begin
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] pb;
    logic [WIDTH-1:0] gb;
    s1_next    = '0;
    b_eff      = ((ALUop == OP_SUB) || (ALUop == OP_SLT)) ? ~b : b;
    pb         = a ^ b_eff;
    gb         = a & b_eff;
    s1_next.op = ALUop;
    s1_next.c0 = (ALUop == OP_ADD) ? c_in :
                 ((ALUop == OP_SUB) || (ALUop == OP_SLT)) ? 1'b1 : 1'b0;
    s1_next.a_msb  = a[WIDTH-1];
    s1_next.bx_msb = b_eff[WIDTH-1];
    case (ALUop)
      OP_AND:  s1_next.logic_res = a & b;
      OP_OR:   s1_next.logic_res = a | b;
      OP_XOR:  s1_next.logic_res = a ^ b;
      OP_NOR:  s1_next.logic_res = ~(a | b);
      default: s1_next.logic_res = '0;
    endcase
    for (int g = 0; g < NG; g++) begin
      s1_next.gp[g] = &pb[4*g +: 4];
      s1_next.gg[g] = gb[4*g+3] | (pb[4*g+3] & gb[4*g+2]) |
                      (pb[4*g+3] & pb[4*g+2] & gb[4*g+1]) |
                      (pb[4*g+3] & pb[4*g+2] & pb[4*g+1] & gb[4*g]);
      s1_next.sum0[4*g +: 4] = cla4(a[4*g +: 4], b_eff[4*g +: 4], 1'b0);
      s1_next.sum1[4*g +: 4] = cla4(a[4*g +: 4], b_eff[4*g +: 4], 1'b1);
    end
  end

  // Second level: each group carry is a flat sum of products of G/P terms and c0.
  always_comb begin
    logic acc;
    logic term;
    acc   = 1'b0;
    term  = 1'b0;
    gc    = '0;
    gc[0] = src.c0;
    for (int i = 1; i <= NG; i++) begin
      acc = 1'b0;
      for (int j = 0; j < i; j++) begin
        term = src.gg[j];
        for (int k = j + 1; k < i; k++) term = term & src.gp[k];
        acc = acc | term;
      end
      term = src.c0;
      for (int k = 0; k < i; k++) term = term & src.gp[k];
      gc[i] = acc | term;
    end
  end

  // Final sum selection, result multiplexing and flag generation.
  always_comb begin
    logic is_arith;
    logic is_sub;
    logic add_ovf;
    sum = '0;
    for (int g = 0; g < NG; g++)
      sum[4*g +: 4] = gc[g] ? src.sum1[4*g +: 4] : src.sum0[4*g +: 4];
    is_arith = (src.op == OP_ADD) || (src.op == OP_SUB) || (src.op == OP_SLT);
    is_sub   = (src.op == OP_SUB) || (src.op == OP_SLT);
    add_ovf  = (src.a_msb == src.bx_msb) && (sum[WIDTH-1] != src.a_msb);
    next_carry    = is_arith ? gc[NG] : 1'b0;
    next_overflow = is_arith ? add_ovf : 1'b0;
    next_slt      = is_sub ? (add_ovf ^ sum[WIDTH-1]) : 1'b0;
    case (src.op)
      OP_ADD, OP_SUB: next_result = sum;
      OP_SLT:         next_result = {{(WIDTH-1){1'b0}}, next_slt};
      default:        next_result = src.logic_res;
    endcase
  end

  assign out_load = !out_valid || out_ready;

  generate
    if (STAGES == 2) begin : g_two_stage
      stage1_t s1_q;
      logic    s1_valid;
      logic    s1_adv;

      assign s1_adv    = s1_valid && out_load;
      assign in_ready  = !reset && (!s1_valid || s1_adv);
      assign src       = s1_q;
      assign src_valid = s1_valid;

      // Stage-1 entry refills whenever it is empty or moving to the output stage.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1_valid <= 1'b0;
          s1_q     <= '0;
        end else if (!s1_valid || s1_adv) begin
          s1_valid <= in_valid;
          if (in_valid) s1_q <= s1_next;
        end
      end
    end else begin : g_one_stage
      assign in_ready  = !reset && out_load;
      assign src       = s1_next;
      assign src_valid = in_valid;
    end
  endgenerate

  // Output stage holds its result stable until the downstream side takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      slt       <= 1'b0;
      zero      <= 1'b0;
    end else if (out_load) begin
      out_valid <= src_valid;
      if (src_valid) begin
        result    <= next_result;
        carry_out <= next_carry;
        overflow  <= next_overflow;
        slt       <= next_slt;
        zero      <= (next_result == '0);
      end
    end
  end

endmodule
